onchip_memory_arbiter: RTL
==========================

// Module: onchip_memory_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter sharing the single-port 1024x32 on-chip RAM.
//  Port 0 is the processor data master; port 1 is the pong video/game-state engine.
//  Round-robin grant, one access per cycle. Read data returns with fixed 1-cycle
//  latency, matching the RAM's registered address and unregistered q output.
// PARAMETERS
//  ADDR_W      10   word address width; RAM depth is 2**ADDR_W
//  DATA_W      32   data width
//  BE_W        4    byteenable width (DATA_W/8)
// PORTS
//  clk                 in   1       system clock
//  reset               in   1       asynchronous, active-high reset
//  m0_address          in   ADDR_W  port 0 word address
//  m0_read / m0_write  in   1       port 0 read/write request (mutually exclusive)
//  m0_byteenable       in   BE_W    port 0 byte lanes (write)
//  m0_writedata        in   DATA_W  port 0 write data
//  m0_waitrequest      out  1       1 = port 0 request not accepted this cycle
//  m0_readdata         out  DATA_W  port 0 read data
//  m0_readdatavalid    out  1       port 0 read data valid
//  m1_*                             same set for port 1
//  mem_address         out  ADDR_W  to RAM address
//  mem_byteenable      out  BE_W    to RAM byteenable
//  mem_chipselect      out  1       to RAM chipselect
//  mem_write           out  1       to RAM write
//  mem_writedata       out  DATA_W  to RAM writedata
//  mem_clken           out  1       to RAM clken, held 1
//  mem_readdata        in   DATA_W  from RAM readdata, valid 1 cycle after issue
// BEHAVIOUR
//  - req_i = mX_read | mX_write. Grant is combinational from the requests and the
//    registered pointer rr_last: if only one port requests, it wins.
//    If both request, the port != rr_last wins.
//  - rr_last updates on the clock edge only when a grant occurs (i.e. to the
//    granted port). No grant leaves rr_last unchanged.
//  - mX_waitrequest = req_X & ~grant_X. Idle ports see waitrequest=0.
//  - A granted request is accepted on that edge. A requester holds its signals
//    stable while waitrequest=1.
//  - mem_* outputs mux the granted port's signals.
//    mem_chipselect = any grant; mem_write = granted port's write.
//    With no grant: mem_chipselect=0, mem_write=0; address/data are don't-care
//    (driven from port 0).
//  - Read return: registered rd_valid and rd_port. On a granted read,
//    rd_valid <= 1 and rd_port <= granted port. Next cycle,
//    mX_readdatavalid = rd_valid & (rd_port==X). Both mX_readdata outputs carry
//    mem_readdata unconditionally.
//  - Writes generate no readdatavalid. Back-to-back reads are pipelined: one
//    readdatavalid per cycle, in issue order.
//  - Read-during-write to the same address is not defined; no ordering
//    guarantee beyond issue order.
//  - Reset (asynchronous): rr_last <= 1 (port 0 wins the first conflict),
//    rd_valid <= 0, rd_port <= 0, so both readdatavalid outputs are 0.
//    While reset is asserted, all grants are forced to 0: waitrequest = req,
//    mem_chipselect = 0. A read issued the cycle before reset asserts is
//    discarded; no readdatavalid is produced.
//  - Simultaneous read on one port and write on the other: the arbiter grants
//    one; the other waits at least one cycle.
//  - Starvation bound: a continuously requesting port is granted within 2 cycles.
// STRUCTURE
//  - Shared package: ADDR_W/DATA_W/BE_W defaults and port-index constants
//    (PORT_CPU=0, PORT_VID=1).
//  - Sub-module rr_arbiter2: req[1:0], clk, reset -> grant[1:0] one-hot plus the
//    rr_last register.
//  - Top level: request/data mux, read-return pipeline register, waitrequest logic.
// TESTING
//  1. Reset release, no requests -> waitrequest 0/0, chipselect 0,
//     readdatavalid 0/0.
//  2. m0 writes 0xDEADBEEF to addr 5 (be=4'hF), then reads addr 5 ->
//     m0_readdatavalid 1 cycle after accept, m0_readdata=0xDEADBEEF,
//     m1_readdatavalid stays 0.
//  3. Both read every cycle (m0 addr 1, m1 addr 2) -> grants alternate 0,1,0,1.
//     Each port gets readdatavalid every other cycle with the correct data.
//  4. m0 write be=4'b0010 data 0x0000AB00 to a word holding 0x11223344; m1 reads
//     it after -> 0x1122AB44.
//  5. m1 read accepted, reset asserted the next cycle -> m1_readdatavalid never
//     asserts. After release, the first conflict is granted to m0.
//  6. m1 alone requests 8 cycles, then m0 joins -> m0 granted on the first
//     conflict cycle (rr_last=1), waitrequest 0 for m0 that cycle.

Source files
------------

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared definitions for the on-chip RAM arbiter: default widths, port indices
// and the round-robin pick function used by the two-way arbiter.
package onchip_memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  localparam int PORT_CPU = 0;
  localparam int PORT_VID = 1;

  // Identifies one of the two requesters; also used as the round-robin pointer.
  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_VID = 1'b1
  } port_sel_e;

  // A lone requester always wins; on a conflict the port that did not win
  // last time gets the grant.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input port_sel_e last);
    logic [1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = (last == SEL_VID) ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

endpackage

// File: rtl/onchip_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant from the requests and
// the registered pointer of the last granted port.
module rr_arbiter2
  import onchip_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  port_sel_e rr_last;

  // Grants are suppressed entirely while reset is held so nothing reaches the RAM.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      grant = rr_pick(req, rr_last);
    end
  end

  // Remember who won; reset points at port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= SEL_VID;
    end else if (|grant) begin
      rr_last <= port_sel_e'(grant[1]);
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between the CPU data master (port 0) and the
// video/game-state engine (port 1). One access per cycle, reads return one cycle
// after acceptance.
module onchip_memory_arbiter
  import onchip_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       read_granted;
  logic       rd_valid;
  port_sel_e  rd_port;

  assign req[PORT_CPU] = m0_read | m0_write;
  assign req[PORT_VID] = m1_read | m1_write;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign m0_waitrequest = req[PORT_CPU] & ~grant[PORT_CPU];
  assign m1_waitrequest = req[PORT_VID] & ~grant[PORT_VID];

  assign read_granted = (grant[PORT_CPU] & m0_read) | (grant[PORT_VID] & m1_read);

  // Steer the winning port onto the RAM; port 0 drives the bus when idle.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    if (grant[PORT_VID]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (grant[PORT_CPU]) begin
      mem_write      = m0_write;
    end
  end

  assign mem_chipselect = |grant;
  assign mem_clken      = 1'b1;

  // Track which port owns the RAM output in the cycle after a read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_port  <= SEL_CPU;
    end else begin
      rd_valid <= read_granted;
      if (read_granted) begin
        rd_port <= port_sel_e'(grant[PORT_VID]);
      end
    end
  end

  assign m0_readdatavalid = rd_valid & (rd_port == SEL_CPU);
  assign m1_readdatavalid = rd_valid & (rd_port == SEL_VID);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
